// File: rtl/buffer_load_pingpong_array_pkg.sv
// buffer_load_pkg: shared constants, bank-select enum and popcount helper
// for the double-buffered load array.
//   IWID_DEF / IDIM_DEF : default channel width / channel count
//   bank_sel_e          : which bank is currently published (active)
//   popcount()          : number of set bits in a word of up to 32 bits
package buffer_load_pkg;

    localparam int IWID_DEF = 8;
    localparam int IDIM_DEF = 4;

    typedef enum logic {
        BANK_A = 1'b0,
        BANK_B = 1'b1
    } bank_sel_e;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < 32; i++) c += 32'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/buffer_load_pingpong_array_if.sv
// buffer_load_pingpong_array_if: load/publish bus of the ping-pong array.
//   load, iMask, iData : masked write into the shadow bank (producer -> array)
//   swap               : publish strobe (producer -> array)
//   oData, oValid      : published operand vector and its completeness flag
//   oFill              : number of shadow channels written since last publish
//   oErr               : refused-publish pulse (strict build only)
// modport master = producer side, modport slave = array side.
interface buffer_load_pingpong_array_if
    import buffer_load_pkg::*;
#(
    parameter int IWID = IWID_DEF,
    parameter int IDIM = IDIM_DEF,
    parameter int CWID = $clog2(IDIM + 1)
);
    logic                 load;
    logic [IDIM-1:0]      iMask;
    logic [IWID-1:0]      iData [IDIM-1:0];
    logic                 swap;
    logic [IWID-1:0]      oData [IDIM-1:0];
    logic                 oValid;
    logic [CWID-1:0]      oFill;
    logic                 oErr;

    modport master (
        output load, iMask, iData, swap,
        input  oData, oValid, oFill, oErr
    );

    modport slave (
        input  load, iMask, iData, swap,
        output oData, oValid, oFill, oErr
    );
endinterface

// File: rtl/buffer_load_pingpong_array_bank.sv
// buffer_load_bank: IDIM x IWID register bank with per-channel write enable.
//   clk, rst_n : clock, asynchronous active-low reset (clears every channel)
//   i_we       : per-channel write enable (already qualified by the caller)
//   i_data     : per-channel write data
//   o_data     : registered bank contents
module buffer_load_bank #(
    parameter int IWID = 8,
    parameter int IDIM = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IDIM-1:0] i_we,
    input  logic [IWID-1:0] i_data [IDIM-1:0],
    output logic [IWID-1:0] o_data [IDIM-1:0]
);
    logic [IWID-1:0] r_mem [IDIM-1:0];

    for (genvar g = 0; g < IDIM; g++) begin : g_ch
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)         r_mem[g] <= '0;
            else if (i_we[g])   r_mem[g] <= i_data[g];
        end
        assign o_data[g] = r_mem[g];
    end
endmodule

// File: rtl/buffer_load_pingpong_array.sv
// buffer_load_pingpong_array: double-buffered, per-channel-masked load array.
// A producer fills the shadow bank channel by channel; a swap strobe publishes
// it atomically on oData while the old active bank becomes the new shadow.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : buffer_load_pingpong_array_if.slave (load/iMask/iData/swap in,
//                oData/oValid/oFill/oErr out)
// Build option: BUFFER_LOAD_STRICT_SWAP_EN -- refuse a swap unless every
// channel of the shadow bank (including this cycle's write) has been written;
// a refused swap pulses oErr. Without it every swap is accepted, oErr is 0.
module buffer_load_pingpong_array
    import buffer_load_pkg::*;
#(
    parameter int IWID = IWID_DEF,
    parameter int IDIM = IDIM_DEF
) (
    input  logic clk,
    input  logic rst_n,
    buffer_load_pingpong_array_if.slave bus
);
    localparam int CWID = $clog2(IDIM + 1);

    bank_sel_e       r_act;
    logic [IDIM-1:0] r_wrFlag;
    logic            r_valid;
    logic [CWID-1:0] r_fill;

    logic [IDIM-1:0] w_wr;
    logic [IDIM-1:0] w_eff;
    logic [IDIM-1:0] w_flagNxt;
    logic [IDIM-1:0] w_weA;
    logic [IDIM-1:0] w_weB;
    logic            w_accept;
    logic [IWID-1:0] w_bankA [IDIM-1:0];
    logic [IWID-1:0] w_bankB [IDIM-1:0];

    assign w_wr  = bus.load ? bus.iMask : '0;
    // A write in the swap cycle lands in the outgoing bank, so it counts.
    assign w_eff = r_wrFlag | w_wr;

`ifdef BUFFER_LOAD_STRICT_SWAP_EN
    assign w_accept = bus.swap & (&w_eff);
`else
    assign w_accept = bus.swap;
`endif

    // Writes always target the shadow bank, even on a refused swap.
    assign w_weA = (r_act == BANK_B) ? w_wr : '0;
    assign w_weB = (r_act == BANK_A) ? w_wr : '0;

    // After an accepted swap the new shadow bank is untouched, so the flags
    // (and oFill) restart from zero even when the swap carried a write.
    assign w_flagNxt = w_accept ? '0 : w_eff;

    buffer_load_bank #(.IWID(IWID), .IDIM(IDIM)) u_bank_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_we   (w_weA),
        .i_data (bus.iData),
        .o_data (w_bankA)
    );

    buffer_load_bank #(.IWID(IWID), .IDIM(IDIM)) u_bank_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_we   (w_weB),
        .i_data (bus.iData),
        .o_data (w_bankB)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act    <= BANK_A;
            r_wrFlag <= '0;
            r_valid  <= 1'b0;
            r_fill   <= '0;
        end else begin
            r_wrFlag <= w_flagNxt;
            r_fill   <= CWID'(popcount(32'(w_flagNxt)));
            if (w_accept) begin
                r_act   <= (r_act == BANK_A) ? BANK_B : BANK_A;
                r_valid <= &w_eff;
            end
        end
    end

`ifdef BUFFER_LOAD_STRICT_SWAP_EN
    logic r_err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_err <= 1'b0;
        else        r_err <= bus.swap & ~w_accept;
    end
    assign bus.oErr = r_err;
`else
    assign bus.oErr = 1'b0;
`endif

    // Output is a pure mux of registered state: no input-to-oData path.
    for (genvar g = 0; g < IDIM; g++) begin : g_out
        assign bus.oData[g] = (r_act == BANK_A) ? w_bankA[g] : w_bankB[g];
    end

    assign bus.oValid = r_valid;
    assign bus.oFill  = r_fill;
endmodule

// File: tb/tb_buffer_load_pingpong_array.sv
// Directed bench for buffer_load_pingpong_array with a reference model and
// an expected-output queue. Honours BUFFER_LOAD_STRICT_SWAP_EN.
module tb_buffer_load_pingpong_array;
    import buffer_load_pkg::*;

`ifdef BUFFER_LOAD_STRICT_SWAP_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [31:0] d;
        logic        v;
        logic [2:0]  f;
        logic        e;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];

    // reference state
    logic [7:0] mb [2][4];
    logic       mact;
    logic [3:0] mflag;
    logic       mvalid;
    logic       merr;

    buffer_load_pingpong_array_if #(.IWID(8), .IDIM(4)) bif ();

    buffer_load_pingpong_array #(.IWID(8), .IDIM(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] obs_data();
        return {bif.oData[3], bif.oData[2], bif.oData[1], bif.oData[0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 4; i++) mb[b][i] = 8'h00;
        mact = 1'b0; mflag = 4'h0; mvalid = 1'b0; merr = 1'b0;
        q.delete();
    endtask

    // Drive one cycle, advance the model, queue the expected outputs, then
    // compare after the edge.
    task automatic step(input string tag, input logic ld, input logic [3:0] m,
                        input logic [31:0] d, input logic sw);
        logic [3:0] wr, eff;
        logic       acc;
        exp_t       e, got;
        bif.load  = ld;
        bif.iMask = m;
        bif.swap  = sw;
        for (int i = 0; i < 4; i++) bif.iData[i] = d[8*i +: 8];
        wr  = ld ? m : 4'h0;
        eff = mflag | wr;
        for (int i = 0; i < 4; i++) if (wr[i]) mb[~mact][i] = d[8*i +: 8];
        acc  = sw && (!STRICT || (&eff));
        merr = STRICT && sw && !acc;
        if (acc) begin
            mact   = ~mact;
            mflag  = 4'h0;
            mvalid = &eff;
        end else begin
            mflag = eff;
        end
        e.tag = tag;
        e.d   = {mb[mact][3], mb[mact][2], mb[mact][1], mb[mact][0]};
        e.v   = mvalid;
        e.f   = 3'(32'(mflag[0]) + 32'(mflag[1]) + 32'(mflag[2]) + 32'(mflag[3]));
        e.e   = merr;
        q.push_back(e);
        @(posedge clk);
        #1;
        got = q.pop_front();
        chk({got.tag, ".data"},  obs_data(),         got.d);
        chk({got.tag, ".valid"}, 32'(bif.oValid),    32'(got.v));
        chk({got.tag, ".fill"},  32'(bif.oFill),     32'(got.f));
        chk({got.tag, ".err"},   32'(bif.oErr),      32'(got.e));
    endtask

    initial begin
        model_reset();
        // reset held with load active
        rst_n     = 1'b0;
        bif.load  = 1'b1;
        bif.iMask = 4'hF;
        bif.swap  = 1'b0;
        bif.iData[3] = 8'd10; bif.iData[2] = 8'd1; bif.iData[1] = 8'd8; bif.iData[0] = 8'd9;
        #12;
        chk("rst.data",  obs_data(),        32'h0);
        chk("rst.valid", 32'(bif.oValid),   32'h0);
        chk("rst.fill",  32'(bif.oFill),    32'h0);
        chk("rst.err",   32'(bif.oErr),     32'h0);
        #5;
        rst_n    = 1'b1;
        bif.load = 1'b0;

        // full load then swap
        step("full_ld", 1'b1, 4'hF, 32'h0A01_0809, 1'b0);
        chk("full_ld.fill4", 32'(bif.oFill), 32'd4);
        chk("full_ld.hidden", obs_data(), 32'h0);
        step("full_sw", 1'b0, 4'h0, 32'h0, 1'b1);
        chk("full_sw.pub",   obs_data(),      32'h0A01_0809);
        chk("full_sw.valid", 32'(bif.oValid), 32'd1);
        chk("full_sw.fill0", 32'(bif.oFill),  32'd0);

        // isolation: shadow writes never reach oData without a swap
        repeat (40) step("iso", 1'b1, 4'hF, 32'h0102_0304, 1'b0);
        chk("iso.stable", obs_data(), 32'h0A01_0809);
        step("iso_sw", 1'b0, 4'h0, 32'h0, 1'b1);
        chk("iso_sw.pub", obs_data(), 32'h0102_0304);

        // partial masks
        step("part_lo", 1'b1, 4'h3, 32'hEEEE_0809, 1'b0);
        chk("part_lo.fill2", 32'(bif.oFill), 32'd2);
        step("part_hi", 1'b1, 4'hC, 32'h0A02_EEEE, 1'b0);
        chk("part_hi.fill4", 32'(bif.oFill), 32'd4);
        step("part_sw", 1'b0, 4'h0, 32'h0, 1'b1);
        chk("part_sw.pub", obs_data(), 32'h0A02_0809);

        // simultaneous load and swap
        step("simul", 1'b1, 4'hF, 32'h0706_0504, 1'b1);
        chk("simul.pub",   obs_data(),      32'h0706_0504);
        chk("simul.valid", 32'(bif.oValid), 32'd1);

        // incomplete swap
        step("inc_ld", 1'b1, 4'h1, 32'h0000_0011, 1'b0);
        step("inc_sw", 1'b0, 4'h0, 32'h0, 1'b1);
`ifdef BUFFER_LOAD_STRICT_SWAP_EN
        chk("inc_sw.err",  32'(bif.oErr),   32'd1);
        chk("inc_sw.hold", obs_data(),      32'h0706_0504);
        step("inc_idle", 1'b0, 4'h0, 32'h0, 1'b0);
        chk("inc_idle.err0", 32'(bif.oErr), 32'd0);
`else
        chk("inc_sw.valid", 32'(bif.oValid), 32'd0);
        chk("inc_sw.pub",   obs_data(),      32'h0A02_0811);
        chk("inc_sw.err0",  32'(bif.oErr),   32'd0);
`endif

        // back-to-back swaps with no loads
        step("b2b_1", 1'b0, 4'h0, 32'h0, 1'b1);
        step("b2b_2", 1'b0, 4'h0, 32'h0, 1'b1);
`ifndef BUFFER_LOAD_STRICT_SWAP_EN
        chk("b2b_2.valid", 32'(bif.oValid), 32'd0);
        chk("b2b_2.pub",   obs_data(),      32'h0A02_0811);
`endif

        // reset in the middle of operation
        step("pre_rst", 1'b1, 4'h6, 32'h0055_5500, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst.data",  obs_data(),      32'h0);
        chk("mrst.valid", 32'(bif.oValid), 32'h0);
        chk("mrst.fill",  32'(bif.oFill),  32'h0);
        model_reset();
        #2;
        rst_n = 1'b1;
        step("post_rst", 1'b1, 4'hF, 32'h0102_0304, 1'b1);
        chk("post_rst.pub", obs_data(), 32'h0102_0304);
        step("idle", 1'b0, 4'h0, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
